// File: rtl/imem_responder_pkg.sv
// -----------------------------------------------------------------------------
// imem_responder_pkg
// Shared definitions for the instruction-memory responder:
//   state_t          FSM state encoding (IDLE / WAIT / RESP)
//   DEFAULT_*        default parameter values
//   clog2()          word-index width for a given store depth
//   word_in_range()  true when a word address falls inside the store
// -----------------------------------------------------------------------------
package imem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int          DEFAULT_DEPTH       = 1024;
   localparam int          DEFAULT_WAIT_STATES = 2;
   localparam logic [31:0] DEFAULT_ERR_INST    = 32'h0000_0000;

   // Smallest r with 2**r >= value (value >= 2).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // word is a byte address with its two low bits already stripped.
   function automatic logic word_in_range(input logic [29:0] word, input int depth);
      return ({2'b00, word} < 32'(depth));
   endfunction

endpackage

// File: rtl/imem_responder_if.sv
// -----------------------------------------------------------------------------
// imem_responder_if
// Fetch-side request/response bus between the fetch stage and the responder.
//   req_valid/req_addr/req_ready   request handshake (byte PC)
//   flush                          branch taken, drop any outstanding fetch
//   resp_valid/resp_ready          response handshake
//   resp_inst/resp_addr/resp_err   returned word, its address, range error
// Modports: master = fetch stage, slave = responder.
// -----------------------------------------------------------------------------
interface imem_responder_if;

   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        flush;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_inst;
   logic [31:0] resp_addr;
   logic        resp_err;

   modport master (
      output req_valid, req_addr, flush, resp_ready,
      input  req_ready, resp_valid, resp_inst, resp_addr, resp_err
   );

   modport slave (
      input  req_valid, req_addr, flush, resp_ready,
      output req_ready, resp_valid, resp_inst, resp_addr, resp_err
   );

endinterface

// File: rtl/imem_store.sv
// -----------------------------------------------------------------------------
// imem_store
// Word array for the program store: synchronous loader write port and a
// registered fetch read port. A read and a write to the same word on the same
// edge return the old contents.
//   clk      rising-edge clock
//   rst      asynchronous active-low reset (clears only the read register)
//   wr_en    loader write enable (already range-qualified)
//   wr_idx   loader word index
//   wr_data  loader write data
//   rd_en    load the read register this edge
//   rd_idx   fetch word index
//   rd_data  registered read data
// -----------------------------------------------------------------------------
module imem_store
   import imem_responder_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int IDX_W = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [31:0]      wr_data,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data
);

   logic [31:0] mem [DEPTH];

   // Contents are deliberately not reset: the loader owns them.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_data;
   end

   // Reset here so resp_inst reads as zero while the block is held in reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
   end

endmodule

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Instruction-memory responder for the fetch stage. Accepts one PC at a time,
// waits WAIT_STATES cycles, then presents the word until the fetch stage takes
// it. A flush drops whatever fetch is outstanding. Out-of-range fetches return
// ERR_INST with resp_err set and the same latency.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   bus        fetch request/response bus (slave side)
//   prog_we    loader write enable
//   prog_addr  loader byte address
//   prog_data  loader write data
// -----------------------------------------------------------------------------
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int          DEPTH       = DEFAULT_DEPTH,
   parameter int          WAIT_STATES = DEFAULT_WAIT_STATES,
   parameter logic [31:0] ERR_INST    = DEFAULT_ERR_INST
) (
   input  logic               clk,
   input  logic               rst,
   imem_responder_if.slave    bus,
   input  logic               prog_we,
   input  logic [31:0]        prog_addr,
   input  logic [31:0]        prog_data
);

   localparam int         IDX_W     = clog2(DEPTH);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
   localparam bit         ZERO_WAIT = (WAIT_STATES == 0);

   state_t      state, state_next;
   logic [3:0]  count, count_next;
   logic [31:0] addr_q;
   logic [31:0] resp_addr_q;
   logic        resp_err_q;
   logic        accept;
   logic        load_resp;
   logic [31:0] fetch_addr;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] rd_data;
   logic        unused_bits;

   // Byte-lane bits of the loader address carry no information.
   assign unused_bits = ^prog_addr[1:0];

   always_comb begin
      state_next = state;
      count_next = count;
      accept     = 1'b0;
      load_resp  = 1'b0;
      fetch_addr = addr_q;
      case (state)
         ST_IDLE: begin
            if (bus.req_valid && !bus.flush) begin
               accept     = 1'b1;
               fetch_addr = bus.req_addr;
               count_next = WAIT_INIT;
               // With no wait states the store is read on the accept edge itself.
               if (ZERO_WAIT) begin
                  state_next = ST_RESP;
                  load_resp  = 1'b1;
               end else begin
                  state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (bus.flush) begin
               state_next = ST_IDLE;
               count_next = '0;
            end else begin
               count_next = count - 4'd1;
               if (count == 4'd1) begin
                  state_next = ST_RESP;
                  load_resp  = 1'b1;
               end
            end
         end
         ST_RESP: begin
            // Flush and a consuming resp_ready both end the response here.
            if (bus.flush || bus.resp_ready) state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            count_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         count       <= '0;
         resp_addr_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (load_resp) begin
            resp_addr_q <= fetch_addr;
            resp_err_q  <= !word_in_range(fetch_addr[31:2], DEPTH);
         end
      end
   end

   // Working copy of the accepted PC; only meaningful between accept and RESP.
   always_ff @(posedge clk) begin
      if (accept) addr_q <= bus.req_addr;
   end

   assign rd_en = load_resp && word_in_range(fetch_addr[31:2], DEPTH);
   assign wr_en = prog_we && word_in_range(prog_addr[31:2], DEPTH);

   imem_store #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_store (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_idx  (prog_addr[IDX_W+1:2]),
      .wr_data (prog_data),
      .rd_en   (rd_en),
      .rd_idx  (fetch_addr[IDX_W+1:2]),
      .rd_data (rd_data)
   );

   // req_ready is forced low while reset is asserted, not just after the next edge.
   assign bus.req_ready  = rst && (state == ST_IDLE);
   assign bus.resp_valid = (state == ST_RESP);
   assign bus.resp_inst  = resp_err_q ? ERR_INST : rd_data;
   assign bus.resp_addr  = resp_addr_q;
   assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
// Drives two responders (WAIT_STATES=2 and WAIT_STATES=0) from one stimulus
// stream. Each has its own scoreboard queue fed at request acceptance and
// drained by a monitor that compares every presented response against a
// behavioural model of the program store.
// -----------------------------------------------------------------------------
module tb_imem_responder;

   localparam int          DEPTH    = 1024;
   localparam logic [31:0] ERR_INST = 32'hDEAD_BEEF;

   typedef struct {
      logic [31:0] addr;
      int          acc;
      logic [31:0] inst;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic        flush = 1'b0;
   logic        resp_ready = 1'b1;
   logic        prog_we = 1'b0;
   logic [31:0] prog_addr = '0;
   logic [31:0] prog_data = '0;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model [DEPTH];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Program store model: any in-range loader write lands on the edge.
   always @(posedge clk) begin
      if (prog_we && (prog_addr >> 2) < DEPTH) model[int'(prog_addr >> 2)] <= prog_data;
   end

   function automatic logic addr_err(input logic [31:0] a);
      return (a >> 2) >= DEPTH;
   endfunction

   // Word the store holds right now for address a (or the error word).
   function automatic logic [31:0] exp_inst(input logic [31:0] a);
      if (addr_err(a)) return ERR_INST;
      return model[int'(a >> 2)];
   endfunction

   task automatic check(input string name, input int k, input logic [31:0] got,
                        input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, k, cyc, got, want);
      end
   endtask

   for (genvar k = 0; k < 2; k++) begin : g_inst
      localparam int W = (k == 0) ? 2 : 0;

      imem_responder_if bus ();

      assign bus.req_valid  = req_valid;
      assign bus.req_addr   = req_addr;
      assign bus.flush      = flush;
      assign bus.resp_ready = resp_ready;

      imem_responder #(
         .DEPTH       (DEPTH),
         .WAIT_STATES (W),
         .ERR_INST    (ERR_INST)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .bus       (bus),
         .prog_we   (prog_we),
         .prog_addr (prog_addr),
         .prog_data (prog_data)
      );

      initial begin : monitor
         exp_t q[$];
         exp_t e;
         bit   idle;
         forever begin
            @(negedge clk);
            if (!rst) begin
               q.delete();
               check("rst_resp_valid", k, 32'(bus.resp_valid), 32'd0);
               check("rst_req_ready", k, 32'(bus.req_ready), 32'd0);
               check("rst_resp_inst", k, bus.resp_inst, 32'd0);
               check("rst_resp_addr", k, bus.resp_addr, 32'd0);
               check("rst_resp_err", k, 32'(bus.resp_err), 32'd0);
            end else begin
               idle = (q.size() == 0);
               check("req_ready", k, 32'(bus.req_ready), 32'(idle));
               if (idle) begin
                  check("resp_valid_idle", k, 32'(bus.resp_valid), 32'd0);
               end else begin
                  // The store is sampled on the last edge before RESP.
                  if (cyc == q[0].acc + W) q[0].inst = exp_inst(q[0].addr);
                  if (cyc <= q[0].acc + W) begin
                     check("resp_valid_early", k, 32'(bus.resp_valid), 32'd0);
                  end else begin
                     check("resp_valid_latency", k, 32'(bus.resp_valid), 32'd1);
                     if (bus.resp_valid) begin
                        check("resp_inst", k, bus.resp_inst, q[0].inst);
                        check("resp_addr", k, bus.resp_addr, q[0].addr);
                        check("resp_err", k, 32'(bus.resp_err), 32'(q[0].err));
                     end
                  end
                  if (flush || (cyc > q[0].acc + W && resp_ready)) void'(q.pop_front());
               end
               if (idle && req_valid && !flush) begin
                  e.addr = req_addr;
                  e.acc  = cyc;
                  e.err  = addr_err(req_addr);
                  e.inst = (W == 0) ? exp_inst(req_addr) : 32'h0;
                  q.push_back(e);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] a);
      req_valid = 1'b1;
      req_addr  = a;
      step();
      req_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) step();
   endtask

   initial begin
      int r;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      // Preload words 0..63 and the top word.
      for (int i = 0; i < 64; i++) begin
         prog_we   = 1'b1;
         prog_addr = 32'(i * 4);
         prog_data = (i == 5) ? 32'hE3A0_1005 : $urandom;
         step();
      end
      prog_addr = 32'((DEPTH - 1) * 4);
      prog_data = $urandom;
      step();
      prog_we = 1'b0;

      // Single fetch of word 5.
      req(32'h14);
      idle_cycles(6);

      // Back-to-back requests with req_valid held high.
      req_valid = 1'b1;
      req_addr  = 32'h0;
      step();
      req_addr  = 32'h4;
      idle_cycles(8);
      req_valid = 1'b0;
      idle_cycles(5);

      // Response held by a stalled fetch stage.
      resp_ready = 1'b0;
      req(32'h14);
      idle_cycles(8);
      resp_ready = 1'b1;
      idle_cycles(4);

      // Flush one cycle after acceptance, then a normal fetch of word 2.
      req(32'h20);
      flush = 1'b1;
      step();
      flush = 1'b0;
      req(32'h8);
      idle_cycles(6);

      // Range boundary.
      req(32'h1000);
      idle_cycles(5);
      req(32'h1003);
      idle_cycles(5);
      req(32'hFFC);
      idle_cycles(5);
      req(32'hFFFF_FFFC);
      idle_cycles(5);

      // Loader write to the word being read on the same edge.
      req(32'h1C);
      step();
      prog_we   = 1'b1;
      prog_addr = 32'h1C;
      prog_data = 32'hCAFE_F00D;
      step();
      prog_we = 1'b0;
      idle_cycles(4);
      req(32'h1C);
      idle_cycles(5);

      // Reset in the middle of a wait, then refetch word 5.
      req(32'h14);
      rst = 1'b0;
      idle_cycles(2);
      rst = 1'b1;
      req(32'h14);
      idle_cycles(5);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         req_valid = ($urandom_range(0, 9) < 7);
         r = $urandom_range(0, 9);
         if (r < 7)      req_addr = 32'($urandom_range(0, 63)) * 32'd4 + 32'($urandom_range(0, 3));
         else if (r < 8) req_addr = 32'((DEPTH - 1) * 4);
         else if (r < 9) req_addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
         else            req_addr = $urandom | 32'h8000_0000;
         resp_ready = ($urandom_range(0, 9) < 6);
         flush      = ($urandom_range(0, 29) == 0);
         prog_we    = ($urandom_range(0, 9) < 2);
         prog_addr  = 32'($urandom_range(0, 63)) * 32'd4;
         if ($urandom_range(0, 19) == 0) prog_addr = prog_addr + 32'(DEPTH * 4);
         prog_data  = $urandom;
         if ($urandom_range(0, 499) == 0) begin
            prog_we = 1'b0;
            rst     = 1'b0;
            idle_cycles(2);
            rst     = 1'b1;
         end else begin
            step();
         end
      end

      req_valid  = 1'b0;
      flush      = 1'b0;
      prog_we    = 1'b0;
      resp_ready = 1'b1;
      idle_cycles(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
